uart_cmd_loader: RTL and testbench



---
 rtl/uart_dbg_pkg.sv | 20 ++
 rtl/uart_cmd_loader_word_assembler.sv | 52 +++++
 rtl/uart_cmd_loader.sv | 172 +++++++++++++++++
 tb/tb_uart_cmd_loader.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_dbg_pkg.sv
// Shared constants for the debug UART command path: command bytes,
// loader FSM encoding and the default inter-byte timeout.
package uart_dbg_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h6C;  // 'l'
    localparam logic [7:0] CMD_RUN  = 8'h72;  // 'r'
    localparam logic [7:0] CMD_HALT = 8'h68;  // 'h'
    localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
    localparam logic [7:0] CMD_PRST = 8'h70;  // 'p'

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_CNT  = 2'd1,
        GET_DATA = 2'd2
    } ld_state_t;

    // 100 ms at 50 MHz
    localparam int DEFAULT_TIMEOUT = 5000000;

endpackage

// File: rtl/uart_cmd_loader_word_assembler.sv
// Big-endian byte-to-word assembler: shifts bytes in MSB first and flags
// a complete word one cycle after its last byte arrives.
module word_assembler
    import uart_dbg_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_vld,
    input  logic [7:0]        byte_in,
    output logic              word_vld,
    output logic [DATA_W-1:0] word
);

    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);

    logic [DATA_W-1:0] shreg_p0;
    logic [CNT_W-1:0]  cnt_p0;
    logic              word_vld_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_p0    <= '0;
            cnt_p0      <= '0;
            word_vld_p1 <= 1'b0;
        end else begin
            word_vld_p1 <= 1'b0;
            if (clr) begin
                shreg_p0 <= '0;
                cnt_p0   <= '0;
            end else if (byte_vld) begin
                shreg_p0 <= (shreg_p0 << 8) | DATA_W'(byte_in);
                if (cnt_p0 == LAST) begin
                    cnt_p0      <= '0;
                    word_vld_p1 <= 1'b1;
                end else begin
                    cnt_p0 <= cnt_p0 + CNT_W'(1);
                end
            end
        end
    end

    // The shift register still holds the full word during the write cycle,
    // even if the next word's first byte is captured at the end of it.
    assign word_vld = word_vld_p1;
    assign word     = shreg_p0;

endmodule

// File: rtl/uart_cmd_loader.sv
// Debug UART command decoder and program loader: run/halt/step/reset
// control of the pipeline and byte-stream loading of instruction memory.
module uart_cmd_loader
    import uart_dbg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int TO_W    = 24,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_done_tick,
    input  logic [7:0]        rx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              clk_enable,
    output logic              step_pulse,
    output logic              load_done,
    output logic              err,
    output logic              busy
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    ld_state_t         state_q, state_d;
    logic              clk_en_q, clk_en_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              step_q, step_d;
    logic              err_q, err_d;
    logic [8:0]        rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              asm_clr;
    logic              asm_byte_vld;
    logic              word_vld;
    logic [DATA_W-1:0] word;

    assign asm_byte_vld = rx_done_tick && (state_q == GET_DATA);

    word_assembler #(
        .DATA_W (DATA_W)
    ) u_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (asm_clr),
        .byte_vld (asm_byte_vld),
        .byte_in  (rx_data),
        .word_vld (word_vld),
        .word     (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clk_en_q  <= 1'b0;
            cpu_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
            rem_q     <= '0;
            addr_q    <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            clk_en_q  <= clk_en_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            step_q    <= step_d;
            err_q     <= err_d;
            rem_q     <= rem_d;
            addr_q    <= addr_d;
            to_q      <= to_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_en_d  = clk_en_q;
        cpu_rst_d = 1'b0;
        busy_d    = 1'b0;
        step_d    = 1'b0;
        err_d     = 1'b0;
        rem_d     = rem_q;
        addr_d    = addr_q;
        to_d      = '0;
        asm_clr   = 1'b0;
        load_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_done_tick) begin
                    case (rx_data)
                        CMD_RUN:  clk_en_d = 1'b1;
                        CMD_HALT: clk_en_d = 1'b0;
                        CMD_STEP: step_d = !clk_en_q;
                        CMD_PRST: cpu_rst_d = 1'b1;
                        CMD_LOAD: begin
                            clk_en_d  = 1'b0;
                            cpu_rst_d = 1'b1;
                            busy_d    = 1'b1;
                            state_d   = GET_CNT;
                        end
                        default:  err_d = 1'b1;
                    endcase
                end
            end

            GET_CNT: begin
                cpu_rst_d = 1'b1;
                busy_d    = 1'b1;
                if (rx_done_tick) begin
                    rem_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                    addr_d  = '0;
                    asm_clr = 1'b1;
                    state_d = GET_DATA;
                end else if (to_q == TO_LAST) begin
                    err_d     = 1'b1;
                    cpu_rst_d = 1'b0;
                    busy_d    = 1'b0;
                    asm_clr   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            GET_DATA: begin
                cpu_rst_d = 1'b1;
                busy_d    = 1'b1;
                if (word_vld) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        load_done = 1'b1;
                        cpu_rst_d = 1'b0;
                        busy_d    = 1'b0;
                        state_d   = IDLE;
                    end
                end
                // A tick always clears the counter first, so a write and a
                // timeout can never land on the same cycle.
                if (rx_done_tick) begin
                    to_d = '0;
                end else if (to_q == TO_LAST) begin
                    err_d     = 1'b1;
                    cpu_rst_d = 1'b0;
                    busy_d    = 1'b0;
                    asm_clr   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign imem_we    = word_vld;
    assign imem_addr  = addr_q;
    assign imem_wdata = word;
    assign cpu_rst    = cpu_rst_q;
    assign clk_enable = clk_en_q;
    assign step_pulse = step_q;
    assign err        = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_cmd_loader.sv
// Directed self-checking bench for uart_cmd_loader (TIMEOUT shortened to 100).
module tb_uart_cmd_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_done_tick = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst, clk_enable, step_pulse, load_done, err, busy;

    int checks = 0;
    int failures = 0;

    logic [7:0]  wr_addr_log [0:1023];
    logic [31:0] wr_data_log [0:1023];
    logic        wr_done_log [0:1023];
    int wr_n = 0, done_n = 0, err_n = 0, step_n = 0;

    uart_cmd_loader #(
        .DATA_W (32),
        .ADDR_W (8),
        .TO_W   (24),
        .TIMEOUT(100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_done_tick(rx_done_tick),
        .rx_data     (rx_data),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_rst     (cpu_rst),
        .clk_enable  (clk_enable),
        .step_pulse  (step_pulse),
        .load_done   (load_done),
        .err         (err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Event log sampled mid-cycle, used by the scenario tasks.
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_we && wr_n < 1024) begin
                wr_addr_log[wr_n] = imem_addr;
                wr_data_log[wr_n] = imem_wdata;
                wr_done_log[wr_n] = load_done;
                wr_n = wr_n + 1;
            end
            if (load_done)  done_n = done_n + 1;
            if (err)        err_n  = err_n + 1;
            if (step_pulse) step_n = step_n + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] full_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b, 8'hC3, b + 8'd7};
    endfunction

    task automatic test_reset();
        logic [39:0] got;
        got = {imem_we, imem_addr, imem_wdata[7:0]};
        checks++;
        if ({cpu_rst, clk_enable, step_pulse, load_done, err, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=000000",
                     {cpu_rst, clk_enable, step_pulse, load_done, err, busy});
        end
        checks++;
        if (imem_we !== 1'b0 || imem_addr !== 8'h00 || imem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_imem got we=%b addr=%h data=%h want 0/00/00000000",
                     imem_we, imem_addr, imem_wdata);
        end
        if (got === 40'h1) $display("note: unexpected partial reset pattern");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_load_two();
        int w0;
        w0 = wr_n;
        send_byte(8'h6C);
        checks++;
        if (busy !== 1'b1 || cpu_rst !== 1'b1 || clk_enable !== 1'b0) begin
            failures++;
            $display("FAIL load_start got busy=%b cpu_rst=%b clk_en=%b want 1/1/0",
                     busy, cpu_rst, clk_enable);
        end
        send_byte(8'h02);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'hDEADBEEF
            || load_done !== 1'b0) begin
            failures++;
            $display("FAIL load_w0 got we=%b addr=%h data=%h done=%b want 1/00/deadbeef/0",
                     imem_we, imem_addr, imem_wdata, load_done);
        end
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h2A);
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd1 || imem_wdata !== 32'h0000002A
            || load_done !== 1'b1 || cpu_rst !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL load_w1 got we=%b addr=%h data=%h done=%b rst=%b busy=%b want 1/01/0000002a/1/1/1",
                     imem_we, imem_addr, imem_wdata, load_done, cpu_rst, busy);
        end
        idle(1);
        checks++;
        if (imem_we !== 1'b0 || load_done !== 1'b0 || cpu_rst !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL load_end got we=%b done=%b rst=%b busy=%b want 0/0/0/0",
                     imem_we, load_done, cpu_rst, busy);
        end
        idle(1);
        checks++;
        if (wr_n - w0 !== 2) begin
            failures++;
            $display("FAIL load_count got=%0d want=2", wr_n - w0);
        end
    endtask

    task automatic test_run_step();
        int s0, e0;
        s0 = step_n; e0 = err_n;
        send_byte(8'h72);
        checks++;
        if (clk_enable !== 1'b1) begin
            failures++;
            $display("FAIL run got clk_enable=%b want=1", clk_enable);
        end
        send_byte(8'h73);
        checks++;
        if (step_pulse !== 1'b0) begin
            failures++;
            $display("FAIL step_while_run got step=%b want=0", step_pulse);
        end
        send_byte(8'h68);
        checks++;
        if (clk_enable !== 1'b0) begin
            failures++;
            $display("FAIL halt got clk_enable=%b want=0", clk_enable);
        end
        send_byte(8'h73);
        checks++;
        if (step_pulse !== 1'b1) begin
            failures++;
            $display("FAIL step_halted got step=%b want=1", step_pulse);
        end
        idle(2);
        checks++;
        if (step_n - s0 !== 1 || err_n - e0 !== 0 || step_pulse !== 1'b0) begin
            failures++;
            $display("FAIL step_count got steps=%0d errs=%0d want 1/0",
                     step_n - s0, err_n - e0);
        end
        send_byte(8'h70);
        checks++;
        if (cpu_rst !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL prst_pulse got cpu_rst=%b busy=%b want 1/0", cpu_rst, busy);
        end
        idle(1);
        checks++;
        if (cpu_rst !== 1'b0) begin
            failures++;
            $display("FAIL prst_end got cpu_rst=%b want=0", cpu_rst);
        end
    endtask

    task automatic test_unknown();
        send_byte(8'h72);
        send_byte(8'h41);
        checks++;
        if (err !== 1'b1 || clk_enable !== 1'b1 || busy !== 1'b0 || cpu_rst !== 1'b0
            || step_pulse !== 1'b0 || imem_we !== 1'b0) begin
            failures++;
            $display("FAIL unknown_cmd got err=%b clk_en=%b busy=%b rst=%b step=%b we=%b want 1/1/0/0/0/0",
                     err, clk_enable, busy, cpu_rst, step_pulse, imem_we);
        end
        idle(1);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL unknown_pulse got err=%b want=0", err);
        end
        send_byte(8'h68);
    endtask

    task automatic test_timeout();
        int w0, seen;
        w0 = wr_n;
        seen = -1;
        send_byte(8'h6C); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (err === 1'b1) begin
                seen = c;
                break;
            end
        end
        checks++;
        if (seen !== 100) begin
            failures++;
            $display("FAIL timeout_cycle got=%0d want=100", seen);
        end
        checks++;
        if (busy !== 1'b0 || cpu_rst !== 1'b0 || clk_enable !== 1'b0 || wr_n !== w0) begin
            failures++;
            $display("FAIL timeout_state got busy=%b rst=%b clk_en=%b writes=%0d want 0/0/0/0",
                     busy, cpu_rst, clk_enable, wr_n - w0);
        end
        send_byte(8'h72);
        checks++;
        if (clk_enable !== 1'b1) begin
            failures++;
            $display("FAIL timeout_recover got clk_enable=%b want=1", clk_enable);
        end
        send_byte(8'h68);
    endtask

    task automatic test_back_to_back_256();
        int w0, d0, bad;
        logic [31:0] wv;
        w0 = wr_n; d0 = done_n; bad = 0;
        send_byte(8'h6C); send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            wv = full_word(i);
            send_byte(wv[31:24]); send_byte(wv[23:16]);
            send_byte(wv[15:8]);  send_byte(wv[7:0]);
        end
        idle(2);
        checks++;
        if (wr_n - w0 !== 256) begin
            failures++;
            $display("FAIL full_count got=%0d want=256", wr_n - w0);
        end else begin
            for (int i = 0; i < 256; i++) begin
                checks++;
                if (wr_addr_log[w0+i] !== 8'(i) || wr_data_log[w0+i] !== full_word(i)
                    || wr_done_log[w0+i] !== (i == 255)) begin
                    failures++;
                    $display("FAIL full_word%0d got addr=%h data=%h done=%b want %h/%h/%b",
                             i, wr_addr_log[w0+i], wr_data_log[w0+i], wr_done_log[w0+i],
                             8'(i), full_word(i), (i == 255));
                end
            end
        end
        checks++;
        if (done_n - d0 !== 1 || imem_addr !== 8'h00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL full_end got dones=%0d addr=%h busy=%b want 1/00/0",
                     done_n - d0, imem_addr, busy);
        end
        if (bad != 0) $display("note: bad=%0d", bad);
    endtask

    task automatic test_reset_midload();
        int w0;
        w0 = wr_n;
        send_byte(8'h6C); send_byte(8'h03);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05); send_byte(8'h06);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cpu_rst, clk_enable, step_pulse, load_done, err, busy, imem_we} !== 7'b0
            || imem_addr !== 8'h00 || imem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL async_reset got ctrl=%b addr=%h data=%h want 0/00/00000000",
                     {cpu_rst, clk_enable, step_pulse, load_done, err, busy, imem_we},
                     imem_addr, imem_wdata);
        end
        checks++;
        if (wr_n - w0 !== 1) begin
            failures++;
            $display("FAIL midload_writes got=%0d want=1", wr_n - w0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send_byte(8'h6C); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 32'h11223344
            || load_done !== 1'b1) begin
            failures++;
            $display("FAIL reload got we=%b addr=%h data=%h done=%b want 1/00/11223344/1",
                     imem_we, imem_addr, imem_wdata, load_done);
        end
        idle(2);
    endtask

    initial begin
        idle(2);
        test_reset();
        test_load_two();
        test_run_step();
        test_unknown();
        test_timeout();
        test_back_to_back_256();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
